tc_pe_sched: RTL and testbench

// Job scheduler for one tensor-core dot-product PE (N_MUL fp32 products + fp32 adder tree, fixed latency, no stall input).

---
 rtl/tc_pe_sched.sv | 176 +++++++++++++++++
 tb/tb_tc_pe_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_pe_sched.sv
// Job scheduler for one tensor-core dot-product PE: credit-gated operand issue, latency tracking, FWFT result FIFO.
// Optional perf counters (perf_busy_cyc, perf_stall_cyc) are built when TC_SCHED_PERF_EN is defined.
module tc_pe_sched #(
   parameter int AW         = 10,
   parameter int LW         = 16,
   parameter int DW         = 32,
   parameter int RD_LAT     = 1,
   parameter int PE_LAT     = 12,
   parameter int FIFO_DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [AW-1:0] cmd_base,
   input  logic [LW-1:0] cmd_len,
   output logic          buf_rd_en,
   output logic [AW-1:0] buf_rd_addr,
   input  logic [DW-1:0] pe_out_data,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW-1:0] res_data,
   output logic          res_last,
   output logic          busy,
   output logic          done
`ifdef TC_SCHED_PERF_EN
   ,
   output logic [31:0]   perf_busy_cyc,
   output logic [31:0]   perf_stall_cyc
`endif
);

   localparam int PL = RD_LAT + PE_LAT;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] LP_DEPTH = (CW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t         r_state;
   logic           r_cmd_ready;
   logic [AW-1:0]  r_base;
   logic [LW-1:0]  r_len;
   logic [LW-1:0]  r_idx;
   logic [CW-1:0]  r_inflight;
   logic           r_rd_en;
   logic [AW-1:0]  r_rd_addr;
   logic           r_rd_last;
   logic [PL-1:0]  r_vld;
   logic [PL-1:0]  r_lst;
   logic [DW:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0]  r_wr_ptr;
   logic [PW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_fifo_cnt;

   logic           w_accept;
   logic [CW:0]    w_occ;
   logic           w_credit;
   logic           w_issue;
   logic           w_last_step;
   logic           w_push;
   logic           w_pop;

   assign w_accept    = cmd_valid & r_cmd_ready;
   assign w_occ       = {1'b0, r_fifo_cnt} + {1'b0, r_inflight};
   assign w_credit    = w_occ < LP_DEPTH;
   assign w_issue     = (r_state == S_RUN) && w_credit;
   assign w_last_step = r_idx == (r_len - LW'(1));
   assign w_push      = r_vld[PL-1];
   assign w_pop       = res_valid & res_ready;

   // Issue decision and inflight credit share one edge; the strobe is visible the following cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b0;
         r_base      <= '0;
         r_len       <= '0;
         r_idx       <= '0;
         r_rd_en     <= 1'b0;
         r_rd_addr   <= '0;
         r_rd_last   <= 1'b0;
      end else begin
         r_rd_en   <= w_issue;
         r_rd_last <= w_issue & w_last_step;
         if (w_issue) begin
            r_rd_addr <= r_base + AW'(r_idx);
            r_idx     <= r_idx + LW'(1);
         end
         case (r_state)
            S_IDLE: begin
               r_cmd_ready <= 1'b1;
               if (w_accept) begin
                  r_base      <= cmd_base;
                  r_len       <= cmd_len;
                  r_idx       <= '0;
                  r_cmd_ready <= 1'b0;
                  r_state     <= (cmd_len == '0) ? S_DRAIN : S_RUN;
               end
            end
            S_RUN: begin
               if (w_issue && w_last_step) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (r_inflight == '0) begin
                  r_state     <= S_IDLE;
                  r_cmd_ready <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inflight <= '0;
         r_vld      <= '0;
         r_lst      <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fifo_cnt <= '0;
      end else begin
         case ({w_issue, w_push})
            2'b10:   r_inflight <= r_inflight + CW'(1);
            2'b01:   r_inflight <= r_inflight - CW'(1);
            default: r_inflight <= r_inflight;
         endcase
         r_vld <= {r_vld[PL-2:0], r_rd_en};
         r_lst <= {r_lst[PL-2:0], r_rd_last};
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
            2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {r_lst[PL-1], pe_out_data};
   end

   assign cmd_ready   = r_cmd_ready;
   assign buf_rd_en   = r_rd_en;
   assign buf_rd_addr = r_rd_addr;
   assign res_valid   = r_fifo_cnt != '0;
   assign res_data    = res_valid ? r_mem[r_rd_ptr][DW-1:0] : '0;
   assign res_last    = res_valid ? r_mem[r_rd_ptr][DW] : 1'b0;
   assign busy        = r_state != S_IDLE;
   assign done        = (r_state == S_DRAIN) && (r_inflight == '0);

`ifdef TC_SCHED_PERF_EN
   logic [31:0] r_perf_busy;
   logic [31:0] r_perf_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_busy  <= '0;
         r_perf_stall <= '0;
      end else if (w_accept) begin
         r_perf_busy  <= '0;
         r_perf_stall <= '0;
      end else begin
         if (busy && (r_perf_busy != '1)) r_perf_busy <= r_perf_busy + 32'd1;
         if ((r_state == S_RUN) && !w_credit && (r_perf_stall != '1))
            r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign perf_busy_cyc  = r_perf_busy;
   assign perf_stall_cyc = r_perf_stall;
`endif

endmodule

// File: tb/tb_tc_pe_sched.sv
// Self-checking bench for tc_pe_sched: emulates the PE, models issue/result/done timing from the job rules.
// Build with TC_SCHED_PERF_EN defined to also exercise the perf counters.
module tb_tc_pe_sched;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_base;
   logic [15:0] cmd_len;
   logic        buf_rd_en;
   logic [9:0]  buf_rd_addr;
   logic [31:0] pe_out_data;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_last;
   logic        busy;
   logic        done;
`ifdef TC_SCHED_PERF_EN
   logic [31:0] perf_busy_cyc;
   logic [31:0] perf_stall_cyc;
`endif

   tc_pe_sched #(.AW(10), .LW(16), .DW(32), .RD_LAT(1), .PE_LAT(12), .FIFO_DEPTH(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_len(cmd_len),
      .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .pe_out_data(pe_out_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
      .busy(busy), .done(done)
`ifdef TC_SCHED_PERF_EN
      , .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc)
`endif
   );

   typedef struct packed { logic [9:0] addr; logic last; } a_t;
   typedef struct packed { int due; logic [31:0] val; } p_t;
   typedef struct packed { logic [31:0] val; logic last; int vis; } r_t;

   a_t addr_q[$];
   p_t pe_q[$];
   r_t res_q[$];
   int iss_addr[$];
   int iss_cyc[$];
   int pop_cyc[$];
   int pop_last[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int exp_done = -1;
   int done_cnt = 0;
   int issued = 0;
   int popped = 0;
   logic [15:0] seq = '0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Model: PE emulation plus expected issue/result/done timing, compared every cycle.
   always @(negedge clk) begin
      if (rst) begin
         addr_q.delete();
         pe_q.delete();
         res_q.delete();
         exp_done    = -1;
         pe_out_data = '0;
      end else begin
         logic exp_valid;
         if (pe_q.size() > 0 && pe_q[0].due == cyc) begin
            pe_out_data = pe_q[0].val;
            void'(pe_q.pop_front());
         end else begin
            pe_out_data = 32'hDEAD_BEEF;
         end
         if (buf_rd_en) begin
            if (addr_q.size() == 0) begin
               chk("unexpected_issue", 1, 0);
            end else begin
               a_t a;
               logic [31:0] v;
               a = addr_q.pop_front();
               chk("rd_addr", buf_rd_addr, a.addr);
               v = {seq, 6'd0, a.addr};
               seq++;
               issued++;
               chk("credit_bound", (issued - popped) <= 16, 1);
               pe_q.push_back('{cyc + 13, v});
               res_q.push_back('{v, a.last, cyc + 14});
               if (a.last) exp_done = cyc + 14;
               iss_addr.push_back(int'(buf_rd_addr));
               iss_cyc.push_back(cyc);
            end
         end
         exp_valid = res_q.size() > 0 && res_q[0].vis <= cyc;
         chk("res_valid", res_valid, exp_valid);
         if (res_valid && exp_valid) begin
            chk("res_data", res_data, res_q[0].val);
            chk("res_last", res_last, res_q[0].last);
            if (res_ready) begin
               void'(res_q.pop_front());
               popped++;
               pop_cyc.push_back(cyc);
               pop_last.push_back(int'(res_last));
            end
         end
         chk("done", done, cyc == exp_done);
         if (done) done_cnt++;
         if (cmd_valid && cmd_ready) begin
            for (int i = 0; i < int'(cmd_len); i++)
               addr_q.push_back('{cmd_base + 10'(i), i == int'(cmd_len) - 1});
            if (cmd_len == 16'd0) exp_done = cyc + 1;
         end
      end
   end

   task automatic send_cmd(input logic [9:0] b, input logic [15:0] l);
      int n;
      n = 0;
      while (!cmd_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("cmd_ready_wait", cmd_ready, 1);
      cmd_base  = b;
      cmd_len   = l;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_quiet();
      int n;
      logic q;
      n = 0;
      q = 1'b0;
      while (!q && n < 600) begin
         @(posedge clk); #1;
         q = !busy && !res_valid && res_q.size() == 0 && addr_q.size() == 0;
         n++;
      end
      chk("quiet_wait", q, 1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 0);
      chk({tag, "_buf_rd_en"}, buf_rd_en, 0);
      chk({tag, "_buf_rd_addr"}, buf_rd_addr, 0);
      chk({tag, "_res_valid"}, res_valid, 0);
      chk({tag, "_res_data"}, res_data, 0);
      chk({tag, "_res_last"}, res_last, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   initial begin
      int bi, bp, bd, n;
      rst = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst = 1'b0;

      // 1: base 0x010, len 4, always ready
      bi = iss_addr.size(); bp = pop_cyc.size(); bd = done_cnt;
      send_cmd(10'h010, 16'd4);
      wait_quiet();
      chk("s1_issues", iss_addr.size() - bi, 4);
      chk("s1_pops", pop_cyc.size() - bp, 4);
      if (iss_addr.size() - bi == 4 && pop_cyc.size() - bp == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("s1_addr", iss_addr[bi+i], 32'h10 + i);
            chk("s1_consec", iss_cyc[bi+i] - iss_cyc[bi], i);
            chk("s1_latency", pop_cyc[bp+i] - iss_cyc[bi+i], 14);
            chk("s1_last", pop_last[bp+i], i == 3);
         end
      end
      chk("s1_done_count", done_cnt - bd, 1);

      // 2: len 40 under backpressure, then release
      bi = iss_addr.size(); bp = pop_cyc.size(); bd = done_cnt;
      res_ready = 1'b0;
      send_cmd(10'h100, 16'd40);
      repeat (60) @(posedge clk);
      #1;
      chk("s2_blocked_issues", iss_addr.size() - bi, 16);
      chk("s2_fifo_nonempty", res_valid, 1);
      chk("s2_no_rd_en", buf_rd_en, 0);
      chk("s2_busy", busy, 1);
      res_ready = 1'b1;
      wait_quiet();
      chk("s2_total_issues", iss_addr.size() - bi, 40);
      chk("s2_total_pops", pop_cyc.size() - bp, 40);
      chk("s2_done_count", done_cnt - bd, 1);

      // 3: address wrap
      bi = iss_addr.size();
      send_cmd(10'h3FE, 16'd4);
      wait_quiet();
      chk("s3_issues", iss_addr.size() - bi, 4);
      if (iss_addr.size() - bi == 4) begin
         chk("s3_addr0", iss_addr[bi],   32'h3FE);
         chk("s3_addr1", iss_addr[bi+1], 32'h3FF);
         chk("s3_addr2", iss_addr[bi+2], 32'h000);
         chk("s3_addr3", iss_addr[bi+3], 32'h001);
      end

      // 4: zero-length job
      bi = iss_addr.size(); bp = pop_cyc.size(); bd = done_cnt;
      send_cmd(10'h055, 16'd0);
      wait_quiet();
      chk("s4_issues", iss_addr.size() - bi, 0);
      chk("s4_pops", pop_cyc.size() - bp, 0);
      chk("s4_done_count", done_cnt - bd, 1);

      // 5: asynchronous reset mid-job, then a fresh short job
      send_cmd(10'h000, 16'd20);
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outputs("midrst");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      bi = iss_addr.size(); bp = pop_cyc.size(); bd = done_cnt;
      send_cmd(10'h200, 16'd2);
      wait_quiet();
      chk("s5_issues", iss_addr.size() - bi, 2);
      chk("s5_pops", pop_cyc.size() - bp, 2);
      if (pop_cyc.size() - bp == 2) begin
         chk("s5_last0", pop_last[bp], 0);
         chk("s5_last1", pop_last[bp+1], 1);
      end
      chk("s5_done_count", done_cnt - bd, 1);

`ifdef TC_SCHED_PERF_EN
      // 6: stall counter under sustained backpressure
      bi = iss_addr.size();
      res_ready = 1'b0;
      send_cmd(10'h100, 16'd40);
      n = 0;
      while (iss_addr.size() - bi < 16 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("s6_sixteen_issued", iss_addr.size() - bi, 16);
      repeat (30) @(posedge clk);
      #1;
      chk("s6_stall_ge_30", perf_stall_cyc >= 32'd30, 1);
      chk("s6_busy_ge_stall", perf_busy_cyc >= perf_stall_cyc, 1);
      res_ready = 1'b1;
      wait_quiet();
      chk("s6_total_issues", iss_addr.size() - bi, 40);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
